// File: rtl/game_controller_pkg.sv
// Shared encodings and constants for the coin-catcher round sequencer.
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int TICKS_PER_SEC = 5;
  localparam int READY_TICKS   = 15;
  localparam int LEVEL_STEP    = 20;
  localparam int LEVEL_THR1    = LEVEL_STEP;
  localparam int LEVEL_THR2    = 2 * LEVEL_STEP;
  localparam int LEVEL_THR3    = 3 * LEVEL_STEP;

  localparam logic [3:0] COIN_BOTTOM = 4'd15;

  // Threshold compare instead of a divide; anything past the top threshold is level 3.
  function automatic logic [1:0] score_level(input logic [7:0] s, input int step);
    if (int'(s) >= 3 * step) return 2'd3;
    else if (int'(s) >= 2 * step) return 2'd2;
    else if (int'(s) >= step) return 2'd1;
    else return 2'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_controller_edge_detect.sv
// Registers a level input and emits a one-cycle pulse on its registered rising edge.
`default_nettype none

module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic cur;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// Round sequencer: idle / get-ready / play / pause / game-over, with round timer,
// coin step pacing, miss detection, lives and score-derived difficulty level.
`default_nettype none

module game_controller #(
  parameter int TICKS_PER_SEC = game_pkg::TICKS_PER_SEC,
  parameter int ROUND_SECS    = 60,
  parameter int READY_TICKS   = game_pkg::READY_TICKS,
  parameter int LIVES         = 3,
  parameter int LEVEL_STEP    = game_pkg::LEVEL_STEP,
  parameter int MAX_LEVEL     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] coin_y,
  input  logic       caught,
  input  logic [7:0] score,
  output logic       round_rst_n,
  output logic       coin_en,
  output logic       coin_step,
  output logic [2:0] state,
  output logic [6:0] time_left,
  output logic [1:0] lives_left,
  output logic [1:0] level,
  output logic       game_over
);

  import game_pkg::*;

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RDY_W = (READY_TICKS > 1) ? $clog2(READY_TICKS) : 1;

  state_t           st;
  logic [SUB_W-1:0] sub_cnt;
  logic [RDY_W-1:0] ready_cnt;
  logic [1:0]       step_cnt;
  logic [3:0]       prev_y;
  logic             bottom_evt;
  logic             start_edge;
  logic             pause_edge;
  logic             restart;
  logic [1:0]       raw_level;
  logic [1:0]       level_calc;

  edge_detect u_start_edge (.clk(clk), .reset(reset), .din(start), .rise(start_edge));
  edge_detect u_pause_edge (.clk(clk), .reset(reset), .din(pause), .rise(pause_edge));

  assign raw_level  = score_level(score, LEVEL_STEP);
  assign level_calc = (int'(raw_level) > MAX_LEVEL) ? 2'(MAX_LEVEL) : raw_level;
  assign restart    = start_edge && (st == ST_IDLE || st == ST_PAUSE || st == ST_OVER);
  assign state      = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= ST_IDLE;
      round_rst_n <= 1'b1;
      coin_en     <= 1'b0;
      coin_step   <= 1'b0;
      time_left   <= 7'(ROUND_SECS);
      lives_left  <= 2'(LIVES);
      level       <= 2'd0;
      game_over   <= 1'b0;
      sub_cnt     <= '0;
      ready_cnt   <= '0;
      step_cnt    <= 2'd0;
      prev_y      <= 4'd0;
      bottom_evt  <= 1'b0;
    end else begin
      round_rst_n <= 1'b1;
      coin_step   <= 1'b0;
      prev_y      <= coin_y;
      bottom_evt  <= (st == ST_PLAY) && (coin_y == COIN_BOTTOM) && (prev_y != COIN_BOTTOM);

      if (restart) begin
        round_rst_n <= 1'b0;
        st          <= ST_READY;
        coin_en     <= 1'b0;
        game_over   <= 1'b0;
        time_left   <= 7'(ROUND_SECS);
        lives_left  <= 2'(LIVES);
        level       <= 2'd0;
        sub_cnt     <= '0;
        ready_cnt   <= '0;
        step_cnt    <= 2'd0;
        bottom_evt  <= 1'b0;
      end else begin
        // A pending miss is applied whatever state the FSM moves to this cycle.
        if (bottom_evt && !caught && lives_left != 2'd0)
          lives_left <= lives_left - 2'd1;

        case (st)
          ST_READY: begin
            if (ready_cnt == RDY_W'(READY_TICKS - 1)) begin
              ready_cnt <= '0;
              st        <= ST_PLAY;
              coin_en   <= 1'b1;
            end else begin
              ready_cnt <= ready_cnt + RDY_W'(1);
            end
          end
          ST_PLAY: begin
            if (time_left == 7'd0 || lives_left == 2'd0) begin
              st        <= ST_OVER;
              coin_en   <= 1'b0;
              game_over <= 1'b1;
            end else if (pause_edge) begin
              st      <= ST_PAUSE;
              coin_en <= 1'b0;
            end else begin
              if (sub_cnt == SUB_W'(TICKS_PER_SEC - 1)) begin
                sub_cnt <= '0;
                if (time_left != 7'd0) time_left <= time_left - 7'd1;
              end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
              end
              // Step period is (4 - level) ticks and restarts on every level change.
              if (level_calc != level) begin
                level    <= level_calc;
                step_cnt <= 2'd0;
              end else if (step_cnt == 2'd3 - level) begin
                coin_step <= 1'b1;
                step_cnt  <= 2'd0;
              end else begin
                step_cnt <= step_cnt + 2'd1;
              end
            end
          end
          ST_PAUSE: begin
            if (pause_edge) begin
              st      <= ST_PLAY;
              coin_en <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
